// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard unit
package pipe_pkg;

  localparam int PIPE_REG_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - forwarding source select for one EXE operand
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_W = PIPE_REG_W
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] writereg_m,
  input  logic [REG_W-1:0] writereg_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  output logic [1:0]       sel
);

  // MEM holds the younger result, so it is checked before WB; r0 never forwards.
  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (writereg_m != '0) && (writereg_m == src)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && (writereg_w != '0) && (writereg_w == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward control for IF/ID and ID/EXE
// Optional HAZ_PERF_CNT_EN adds saturating event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int REG_W      = PIPE_REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] writereg_e,
  input  logic [REG_W-1:0] writereg_m,
  input  logic [REG_W-1:0] writereg_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memtoreg_e,
  input  logic             branch_taken_e,
  input  logic             mc_start_e,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mc_busy,
  output logic             mc_done
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_lu_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_mc_cnt
`endif
);

  // The start cycle itself is not frozen, so the counter loads LATENCY-2.
  localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 2);

  mc_state_t  state;
  logic [3:0] mc_cnt;
  logic       load_use;
  logic       flush;
  logic       bubble;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mc_cnt  <= '0;
      mc_done <= 1'b0;
    end else begin
      mc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mc_start_e && !branch_taken_e) begin
            state  <= BUSY;
            mc_cnt <= MC_LOAD;
          end
        end
        BUSY: begin
          if (mc_cnt == 4'd0) begin
            state   <= IDLE;
            mc_done <= 1'b1;
          end else begin
            mc_cnt <= mc_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mc_busy  = (state == BUSY);
  assign load_use = memtoreg_e && regwrite_e && (writereg_e != '0) &&
                    ((writereg_e == rs_d) || (writereg_e == rt_d));
  assign flush    = !mc_busy && branch_taken_e;
  assign bubble   = !mc_busy && !branch_taken_e && load_use;

  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    ifid_clr = 1'b0;
    idex_en  = 1'b1;
    idex_clr = 1'b0;
    if (mc_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
    end else if (flush) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (bubble) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src        (rs_e),
    .writereg_m (writereg_m),
    .writereg_w (writereg_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .sel        (fwd_a_e)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src        (rt_e),
    .writereg_m (writereg_m),
    .writereg_w (writereg_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .sel        (fwd_b_e)
  );

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_cnt    <= '0;
      perf_flush_cnt <= '0;
      perf_mc_cnt    <= '0;
    end else begin
      if (bubble && (perf_lu_cnt != 32'hFFFF_FFFF)) begin
        perf_lu_cnt <= perf_lu_cnt + 32'd1;
      end
      if (flush && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
      if (mc_busy && (perf_mc_cnt != 32'hFFFF_FFFF)) begin
        perf_mc_cnt <= perf_mc_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard unit that drives the enable and clear pins of the IF/ID and ID/EXE pipeline registers, and the PC enable.
- Detects load-use hazards and inserts one bubble.
- Flushes on taken branches resolved in EXE.
- Freezes the front of the pipe while a multi-cycle mul/div occupies EXE, using a countdown FSM.
- Generates EXE-stage forwarding selects.

Parameters:
- MC_LATENCY, 4: total cycles a multi-cycle op occupies EXE; legal range 2..16.
- REG_W, 5: register-index width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rs_d, rt_d  in  REG_W  source registers of the instruction in ID
- rs_e, rt_e  in  REG_W  source registers of the instruction in EXE
- writereg_e, writereg_m, writereg_w  in  REG_W  destination register in EXE, MEM, WB
- regwrite_e, regwrite_m, regwrite_w  in  1  write-enable flag in EXE, MEM, WB
- memtoreg_e  in  1  instruction in EXE is a load
- branch_taken_e  in  1  branch resolved taken in EXE
- mc_start_e  in  1  multi-cycle op entered EXE this cycle
- pc_en  out  1  PC update enable
- ifid_en, ifid_clr  out  1  IF/ID register enable and clear
- idex_en, idex_clr  out  1  ID/EXE register enable and clear
- fwd_a_e, fwd_b_e  out  2  forwarding selects: 00 regfile, 01 WB, 10 MEM
- mc_busy  out  1  FSM is in BUSY
- mc_done  out  1  registered, one-cycle pulse when the op completes

Behaviour:
- FSM states: IDLE, BUSY. Countdown counter mc_cnt is 4 bits.
- Reset (asynchronous):
  - state=IDLE, mc_cnt=0, mc_done=0.
  - Combinational outputs then read pc_en=1, ifid_en=1, idex_en=1, clears=0, fwd selects=00.
- IDLE, mc_start_e=1, branch_taken_e=0: next state=BUSY, mc_cnt<=MC_LATENCY-2.
- BUSY:
  - pc_en=0, ifid_en=0, idex_en=0, all clears=0. The front of the pipe is frozen.
  - When mc_cnt!=0: mc_cnt decrements each cycle.
  - When mc_cnt==0: next state=IDLE and mc_done<=1 for exactly one cycle.
  - Net effect: the pipe is frozen for exactly MC_LATENCY-1 cycles after the start cycle.
- mc_start_e is ignored while in BUSY.
- mc_start_e with branch_taken_e in the same cycle: branch wins and the FSM stays IDLE.
- Branch flush (state IDLE, branch_taken_e=1): ifid_clr=1, idex_clr=1, all enables=1.
- Load-use hazard:
  - Condition: memtoreg_e & regwrite_e & writereg_e!=0 & (writereg_e==rs_d | writereg_e==rt_d).
  - Response: pc_en=0, ifid_en=0, idex_en=1, idex_clr=1. Exactly one bubble; the hazard clears the next cycle as the load moves to MEM.
- Priority: reset > BUSY > branch flush > load-use > normal (all enables 1, clears 0).
- Forwarding (combinational, independent of stall state):
  - fwd_a_e=10 if regwrite_m & writereg_m!=0 & writereg_m==rs_e.
  - else fwd_a_e=01 if regwrite_w & writereg_w!=0 & writereg_w==rs_e.
  - else fwd_a_e=00.
  - fwd_b_e follows the same rules using rt_e.
  - MEM has priority over WB.
- Reset asserted mid-BUSY: immediate return to IDLE, pipe released, no mc_done pulse.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds three 32-bit outputs: perf_lu_cnt, perf_flush_cnt, perf_mc_cnt.
  - Counted events: load-use bubble cycles, branch-flush cycles, BUSY cycles.
  - Each counter increments once per qualifying cycle, saturates at 32'hFFFF_FFFF, and clears on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - FSM state typedef (IDLE, BUSY).
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_W default.
- One natural sub-module: fwd_sel, a single operand-select comparator instantiated twice (operand A and operand B).
- FSM, load-use and flush logic stay in the top level.

Test Plan:
- Load-use: writereg_e=5, memtoreg_e=1, regwrite_e=1, rs_d=5 -> one cycle of pc_en=0, ifid_en=0, idex_clr=1; next cycle all enables 1.
- Load to r0: writereg_e=0, rs_d=0 -> no stall.
- Multi-cycle, MC_LATENCY=4: mc_start_e pulse at cycle N -> mc_busy=1 and enables=0 in cycles N+1..N+3; mc_done=1 in cycle N+4 only; enables=1 in cycle N+4.
- Branch vs load-use: branch_taken_e=1 with a load-use condition in the same cycle -> ifid_clr=1, idex_clr=1, pc_en=1.
- Forwarding: writereg_m=7 and writereg_w=7, both regwrite, rs_e=7 -> fwd_a_e=10; drop regwrite_m -> fwd_a_e=01; rt_e=3 -> fwd_b_e=00.
- Reset in BUSY: assert reset during the second BUSY cycle -> outputs return to reset values that same cycle; no mc_done pulse afterwards.
